sc_microsequencer: RTL and testbench



---
 rtl/sc_microsequencer.sv | 166 ++++++++++++++++
 tb/tb_sc_microsequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_microsequencer.sv
// sc_microsequencer: Moore FSM sequencing fetch/decode/execute/PC-update for uDataPath.
// In: clock, async low reset, IR fields, PSR flags, step. Out: dec/mux/ALU selects, strobes, halt, count.
module sc_microsequencer #(
    parameter int unsigned DATAWIDTH_DECODER_SELECTION = 6,
    parameter int unsigned DATAWIDTH_MUX_SELECTION     = 6,
    parameter int unsigned DATAWIDTH_ALU_SELECTION     = 4,
    parameter int unsigned SEL_PC                      = 32,
    parameter int unsigned SEL_IMM13                   = 33,
    parameter int unsigned SEL_DISP                    = 34,
    parameter int unsigned SEL_CONST4                  = 35,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_CODE_ADD   = 4'h0,
    parameter logic [DATAWIDTH_ALU_SELECTION-1:0] ALU_CODE_PASSA = 4'hE,
    parameter bit          SINGLE_STEP_EN              = 1'b0,
    parameter int unsigned COUNT_WIDTH                 = 16
) (
    input  logic                                   SC_MICROSEQ_CLOCK_50,
    input  logic                                   SC_MICROSEQ_Reset_InLow,
    input  logic [1:0]                             SC_MICROSEQ_RegIR_OP,
    input  logic [4:0]                             SC_MICROSEQ_RegIR_RD,
    input  logic [2:0]                             SC_MICROSEQ_RegIR_OP2,
    input  logic [5:0]                             SC_MICROSEQ_RegIR_OP3,
    input  logic [4:0]                             SC_MICROSEQ_RegIR_RS1,
    input  logic                                   SC_MICROSEQ_RegIR_BIT13,
    input  logic [4:0]                             SC_MICROSEQ_RegIR_RS2,
    input  logic                                   SC_MICROSEQ_Overflow_InHigh,
    input  logic                                   SC_MICROSEQ_Carry_InHigh,
    input  logic                                   SC_MICROSEQ_Negative_InHigh,
    input  logic                                   SC_MICROSEQ_Zero_InHigh,
    input  logic                                   SC_MICROSEQ_Step_InHigh,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_MICROSEQ_DecoderSelectionWrite_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQ_MUXSelectionBUSA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQ_MUXSelectionBUSB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_MICROSEQ_ALUSelection_Out,
    output logic                                   SC_MICROSEQ_RegIRLoad_OutHigh,
    output logic                                   SC_MICROSEQ_FlagWrite_OutHigh,
    output logic                                   SC_MICROSEQ_Halt_OutHigh,
    output logic [COUNT_WIDTH-1:0]                 SC_MICROSEQ_InstrCount_Out
);

    localparam int unsigned DW = DATAWIDTH_DECODER_SELECTION;
    localparam int unsigned MW = DATAWIDTH_MUX_SELECTION;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC      = 4'd3,
        S_BRANCH    = 4'd4,
        S_CALL      = 4'd5,
        S_PC_BRANCH = 4'd6,
        S_PC_INC    = 4'd7,
        S_HALT      = 4'd8
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   br_taken;

    // bit 5 of OP3 has no role in the ALU encoding used here
    logic unused_op3;
    assign unused_op3 = SC_MICROSEQ_RegIR_OP3[5];

    always_comb begin
        br_taken = 1'b0;
        case (SC_MICROSEQ_RegIR_RD[3:0])
            4'b1000: br_taken = 1'b1;
            4'b0001: br_taken = SC_MICROSEQ_Zero_InHigh;
            4'b1001: br_taken = ~SC_MICROSEQ_Zero_InHigh;
            4'b0101: br_taken = SC_MICROSEQ_Carry_InHigh;
            4'b0110: br_taken = SC_MICROSEQ_Negative_InHigh;
            4'b0111: br_taken = SC_MICROSEQ_Overflow_InHigh;
            default: br_taken = 1'b0;
        endcase
    end

    // next state and instruction counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!SINGLE_STEP_EN || SC_MICROSEQ_Step_InHigh)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                cnt_d   = cnt_q + COUNT_WIDTH'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (SC_MICROSEQ_RegIR_OP)
                    2'b10:   state_d = S_EXEC;
                    2'b01:   state_d = S_CALL;
                    2'b11:   state_d = S_HALT;
                    default: state_d = (SC_MICROSEQ_RegIR_OP2 == 3'b010) ?
                                       S_BRANCH : S_PC_INC;
                endcase
            end
            S_EXEC:   state_d = S_PC_INC;
            S_BRANCH: state_d = br_taken ? S_PC_BRANCH : S_PC_INC;
            S_CALL:   state_d = S_PC_BRANCH;
            S_PC_BRANCH, S_PC_INC:
                state_d = SINGLE_STEP_EN ? S_IDLE : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SC_MICROSEQ_CLOCK_50 or negedge SC_MICROSEQ_Reset_InLow) begin
        if (!SC_MICROSEQ_Reset_InLow) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode; reset forces IDLE so outputs go idle at once
    always_comb begin
        SC_MICROSEQ_DecoderSelectionWrite_Out = '1;
        SC_MICROSEQ_MUXSelectionBUSA_Out      = '1;
        SC_MICROSEQ_MUXSelectionBUSB_Out      = '1;
        SC_MICROSEQ_ALUSelection_Out          = ALU_CODE_PASSA;
        SC_MICROSEQ_RegIRLoad_OutHigh         = 1'b0;
        SC_MICROSEQ_FlagWrite_OutHigh         = 1'b0;
        SC_MICROSEQ_Halt_OutHigh              = 1'b0;
        case (state_q)
            S_FETCH: SC_MICROSEQ_RegIRLoad_OutHigh = 1'b1;
            S_EXEC: begin
                SC_MICROSEQ_MUXSelectionBUSA_Out =
                    {{(MW-5){1'b0}}, SC_MICROSEQ_RegIR_RS1};
                SC_MICROSEQ_MUXSelectionBUSB_Out = SC_MICROSEQ_RegIR_BIT13 ?
                    MW'(SEL_IMM13) : {{(MW-5){1'b0}}, SC_MICROSEQ_RegIR_RS2};
                SC_MICROSEQ_ALUSelection_Out =
                    DATAWIDTH_ALU_SELECTION'(SC_MICROSEQ_RegIR_OP3[3:0]);
                SC_MICROSEQ_FlagWrite_OutHigh = SC_MICROSEQ_RegIR_OP3[4];
                // r0 is hard-wired zero, so writes to it are suppressed
                if (SC_MICROSEQ_RegIR_RD != 5'd0)
                    SC_MICROSEQ_DecoderSelectionWrite_Out =
                        {{(DW-5){1'b0}}, SC_MICROSEQ_RegIR_RD};
            end
            S_CALL: begin
                SC_MICROSEQ_MUXSelectionBUSA_Out      = MW'(SEL_PC);
                SC_MICROSEQ_ALUSelection_Out          = ALU_CODE_PASSA;
                SC_MICROSEQ_DecoderSelectionWrite_Out = DW'(15);
            end
            S_PC_BRANCH: begin
                SC_MICROSEQ_MUXSelectionBUSA_Out      = MW'(SEL_PC);
                SC_MICROSEQ_MUXSelectionBUSB_Out      = MW'(SEL_DISP);
                SC_MICROSEQ_ALUSelection_Out          = ALU_CODE_ADD;
                SC_MICROSEQ_DecoderSelectionWrite_Out = DW'(SEL_PC);
            end
            S_PC_INC: begin
                SC_MICROSEQ_MUXSelectionBUSA_Out      = MW'(SEL_PC);
                SC_MICROSEQ_MUXSelectionBUSB_Out      = MW'(SEL_CONST4);
                SC_MICROSEQ_ALUSelection_Out          = ALU_CODE_ADD;
                SC_MICROSEQ_DecoderSelectionWrite_Out = DW'(SEL_PC);
            end
            S_HALT:  SC_MICROSEQ_Halt_OutHigh = 1'b1;
            default: ;
        endcase
    end

    assign SC_MICROSEQ_InstrCount_Out = cnt_q;

endmodule

// File: tb/tb_sc_microsequencer.sv
// tb_sc_microsequencer: scoreboard bench for sc_microsequencer.
// Free-running instance plus a single-step instance; per-cycle output bundles compared.
module tb_sc_microsequencer;

    localparam int K_ALU  = 0;
    localparam int K_BT   = 1;
    localparam int K_BN   = 2;
    localparam int K_CALL = 3;
    localparam int K_NOP  = 4;
    localparam int K_HALT = 5;

    logic       clk = 1'b0;
    logic       rst0, rst1, step;
    logic [1:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] op2;
    logic [5:0] op3;
    logic       b13, fv, fc, fn, fz;

    logic [5:0]  dec0, a0, b0, dec1, a1, b1;
    logic [3:0]  alu0, alu1;
    logic        irl0, fw0, h0, irl1, fw1, h1;
    logic [15:0] cnt0, cnt1;

    typedef struct packed {
        logic        inst;
        logic [40:0] v;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  exp_cnt0 = 0;

    always #5 clk = ~clk;

    sc_microsequencer u_free (
        .SC_MICROSEQ_CLOCK_50(clk), .SC_MICROSEQ_Reset_InLow(rst0),
        .SC_MICROSEQ_RegIR_OP(op), .SC_MICROSEQ_RegIR_RD(rd),
        .SC_MICROSEQ_RegIR_OP2(op2), .SC_MICROSEQ_RegIR_OP3(op3),
        .SC_MICROSEQ_RegIR_RS1(rs1), .SC_MICROSEQ_RegIR_BIT13(b13),
        .SC_MICROSEQ_RegIR_RS2(rs2),
        .SC_MICROSEQ_Overflow_InHigh(fv), .SC_MICROSEQ_Carry_InHigh(fc),
        .SC_MICROSEQ_Negative_InHigh(fn), .SC_MICROSEQ_Zero_InHigh(fz),
        .SC_MICROSEQ_Step_InHigh(1'b0),
        .SC_MICROSEQ_DecoderSelectionWrite_Out(dec0),
        .SC_MICROSEQ_MUXSelectionBUSA_Out(a0),
        .SC_MICROSEQ_MUXSelectionBUSB_Out(b0),
        .SC_MICROSEQ_ALUSelection_Out(alu0),
        .SC_MICROSEQ_RegIRLoad_OutHigh(irl0),
        .SC_MICROSEQ_FlagWrite_OutHigh(fw0),
        .SC_MICROSEQ_Halt_OutHigh(h0),
        .SC_MICROSEQ_InstrCount_Out(cnt0)
    );

    sc_microsequencer #(.SINGLE_STEP_EN(1'b1)) u_step (
        .SC_MICROSEQ_CLOCK_50(clk), .SC_MICROSEQ_Reset_InLow(rst1),
        .SC_MICROSEQ_RegIR_OP(op), .SC_MICROSEQ_RegIR_RD(rd),
        .SC_MICROSEQ_RegIR_OP2(op2), .SC_MICROSEQ_RegIR_OP3(op3),
        .SC_MICROSEQ_RegIR_RS1(rs1), .SC_MICROSEQ_RegIR_BIT13(b13),
        .SC_MICROSEQ_RegIR_RS2(rs2),
        .SC_MICROSEQ_Overflow_InHigh(fv), .SC_MICROSEQ_Carry_InHigh(fc),
        .SC_MICROSEQ_Negative_InHigh(fn), .SC_MICROSEQ_Zero_InHigh(fz),
        .SC_MICROSEQ_Step_InHigh(step),
        .SC_MICROSEQ_DecoderSelectionWrite_Out(dec1),
        .SC_MICROSEQ_MUXSelectionBUSA_Out(a1),
        .SC_MICROSEQ_MUXSelectionBUSB_Out(b1),
        .SC_MICROSEQ_ALUSelection_Out(alu1),
        .SC_MICROSEQ_RegIRLoad_OutHigh(irl1),
        .SC_MICROSEQ_FlagWrite_OutHigh(fw1),
        .SC_MICROSEQ_Halt_OutHigh(h1),
        .SC_MICROSEQ_InstrCount_Out(cnt1)
    );

    wire [40:0] bus0 = {dec0, a0, b0, alu0, irl0, fw0, h0, cnt0};
    wire [40:0] bus1 = {dec1, a1, b1, alu1, irl1, fw1, h1, cnt1};

    function automatic logic [40:0] mk(int dec, int a, int b, int alu,
                                       bit irl, bit fw, bit hlt, int cnt);
        return {6'(dec), 6'(a), 6'(b), 4'(alu), irl, fw, hlt, 16'(cnt)};
    endfunction

    function automatic logic [40:0] idle(int cnt);
        return mk(63, 63, 63, 14, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic inst, input logic [40:0] v);
        sb_t e;
        e.inst = inst;
        e.v    = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_one(input string tag);
        sb_t e;
        @(negedge clk);
        e = sb_q.pop_front();
        check(tag, e.inst ? 64'(bus1) : 64'(bus0), 64'(e.v));
    endtask

    task automatic drain(input string tag);
        while (sb_q.size() > 0) pop_one(tag);
    endtask

    // one instruction on the free-running instance; called at a negedge
    task automatic instr(input string tag, input int kind,
                         input logic [1:0] i_op, input logic [4:0] i_rd,
                         input logic [2:0] i_op2, input logic [5:0] i_op3,
                         input logic [4:0] i_rs1, input logic i_b13,
                         input logic [4:0] i_rs2, input logic [3:0] vcnz);
        op = i_op; rd = i_rd; op2 = i_op2; op3 = i_op3;
        rs1 = i_rs1; b13 = i_b13; rs2 = i_rs2;
        {fv, fc, fn, fz} = vcnz;
        push(1'b0, mk(63, 63, 63, 14, 1'b1, 1'b0, 1'b0, exp_cnt0));
        exp_cnt0++;
        push(1'b0, idle(exp_cnt0));
        case (kind)
            K_ALU: begin
                push(1'b0, mk((i_rd == 0) ? 63 : int'(i_rd), int'(i_rs1),
                              i_b13 ? 33 : int'(i_rs2), int'(i_op3[3:0]),
                              1'b0, i_op3[4], 1'b0, exp_cnt0));
                push(1'b0, mk(32, 32, 35, 0, 1'b0, 1'b0, 1'b0, exp_cnt0));
            end
            K_BT: begin
                push(1'b0, idle(exp_cnt0));
                push(1'b0, mk(32, 32, 34, 0, 1'b0, 1'b0, 1'b0, exp_cnt0));
            end
            K_BN: begin
                push(1'b0, idle(exp_cnt0));
                push(1'b0, mk(32, 32, 35, 0, 1'b0, 1'b0, 1'b0, exp_cnt0));
            end
            K_CALL: begin
                push(1'b0, mk(15, 32, 63, 14, 1'b0, 1'b0, 1'b0, exp_cnt0));
                push(1'b0, mk(32, 32, 34, 0, 1'b0, 1'b0, 1'b0, exp_cnt0));
            end
            K_NOP:
                push(1'b0, mk(32, 32, 35, 0, 1'b0, 1'b0, 1'b0, exp_cnt0));
            default:
                for (int i = 0; i < 20; i++)
                    push(1'b0, mk(63, 63, 63, 14, 1'b0, 1'b0, 1'b1, exp_cnt0));
        endcase
        drain(tag);
    endtask

    task automatic br(input string tag, input bit taken,
                      input logic [3:0] cond, input logic [3:0] vcnz);
        instr(tag, taken ? K_BT : K_BN, 2'b00, {1'b0, cond}, 3'b010,
              6'h00, 5'd0, 1'b0, 5'd0, vcnz);
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; step = 1'b0;
        op = 2'b10; rd = 5'd3; op2 = 3'd0; op3 = 6'h00;
        rs1 = 5'd1; b13 = 1'b0; rs2 = 5'd2;
        {fv, fc, fn, fz} = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_free", 64'(bus0), 64'(idle(0)));
        check("rst_step", 64'(bus1), 64'(idle(0)));
        rst0 = 1'b1;

        instr("add", K_ALU, 2'b10, 5'd3, 3'd0, 6'h00, 5'd1, 1'b0, 5'd2, 4'b0000);
        check("cnt_after_add", 64'(cnt0), 64'd1);
        instr("addcc", K_ALU, 2'b10, 5'd0, 3'd0, 6'h10, 5'd1, 1'b1, 5'd9, 4'b0000);
        instr("alu15", K_ALU, 2'b10, 5'd7, 3'd0, 6'h15, 5'd4, 1'b0, 5'd9, 4'b0000);
        br("be_z1", 1'b1, 4'b0001, 4'b0001);
        br("be_z0", 1'b0, 4'b0001, 4'b0000);
        br("cond3", 1'b0, 4'b0011, 4'b1111);
        br("ba", 1'b1, 4'b1000, 4'b0000);
        br("bn", 1'b0, 4'b0000, 4'b1111);
        br("bne_z0", 1'b1, 4'b1001, 4'b0000);
        br("bne_z1", 1'b0, 4'b1001, 4'b0001);
        br("bc", 1'b1, 4'b0101, 4'b0100);
        br("bn_neg", 1'b1, 4'b0110, 4'b0010);
        br("bv1", 1'b1, 4'b0111, 4'b1000);
        br("bv0", 1'b0, 4'b0111, 4'b0111);
        instr("call", K_CALL, 2'b01, 5'd0, 3'd0, 6'h00, 5'd0, 1'b0, 5'd0, 4'b0000);
        instr("nop", K_NOP, 2'b00, 5'd0, 3'b100, 6'h00, 5'd0, 1'b0, 5'd0, 4'b0000);
        instr("halt", K_HALT, 2'b11, 5'd0, 3'd0, 6'h00, 5'd0, 1'b0, 5'd0, 4'b0000);
        rst0 = 1'b0;
        #1;
        check("halt_rst", 64'(bus0), 64'(idle(0)));

        op = 2'b10; rd = 5'd3; op2 = 3'd0; op3 = 6'h00;
        rs1 = 5'd1; b13 = 1'b0; rs2 = 5'd2;
        @(negedge clk);
        rst1 = 1'b1;
        for (int i = 0; i < 6; i++) push(1'b1, idle(0));
        drain("ss_wait");

        step = 1'b1;
        push(1'b1, mk(63, 63, 63, 14, 1'b1, 1'b0, 1'b0, 0));
        push(1'b1, idle(1));
        push(1'b1, mk(3, 1, 2, 0, 1'b0, 1'b0, 1'b0, 1));
        push(1'b1, mk(32, 32, 35, 0, 1'b0, 1'b0, 1'b0, 1));
        for (int i = 0; i < 4; i++) push(1'b1, idle(1));
        pop_one("ss_step");
        step = 1'b0;
        drain("ss_step");

        step = 1'b1;
        push(1'b1, mk(63, 63, 63, 14, 1'b1, 1'b0, 1'b0, 1));
        push(1'b1, idle(2));
        push(1'b1, mk(3, 1, 2, 0, 1'b0, 1'b0, 1'b0, 2));
        pop_one("ss_rst");
        step = 1'b0;
        drain("ss_rst");
        rst1 = 1'b0;
        #1;
        check("ss_rst_now", 64'(bus1), 64'(idle(0)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
